// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem line responder: line geometry and FSM state encoding.
package pmem_pkg;
   localparam int LINE_BITS   = 256;
   localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

   typedef enum logic [1:0] {PM_IDLE, PM_BUSY, PM_RESP} pmem_state_t;

   typedef logic [LINE_BITS-1:0] line_t;
endpackage

// File: rtl/line_sram.sv
// Line-wide backing store: one synchronous read port and one write port, contents never reset.
module line_sram #(
   parameter int INDEX_BITS = 6,
   parameter int LINE_BITS  = 256
) (
   input  logic                  clk,
   input  logic [INDEX_BITS-1:0] rd_addr,
   output logic [LINE_BITS-1:0]  rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_addr,
   input  logic [LINE_BITS-1:0]  wr_data
);
   logic [LINE_BITS-1:0] mem [0:(1 << INDEX_BITS)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory side of the cache line protocol: fixed-latency whole-line reads and writes
// against an internal line SRAM, with a registered one-cycle completion pulse.
module pmem_line_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_BITS  = 256,
   parameter int INDEX_BITS = 6,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pmem_read,
   input  logic                  pmem_write,
   input  logic [ADDR_WIDTH-1:0] pmem_address,
   input  logic [LINE_BITS-1:0]  pmem_wdata,
   output logic [LINE_BITS-1:0]  pmem_rdata,
   output logic                  pmem_resp,
   output logic                  proto_err
);
   import pmem_pkg::pmem_state_t;
   import pmem_pkg::PM_IDLE;
   import pmem_pkg::PM_BUSY;
   import pmem_pkg::PM_RESP;

   localparam int         OFFSET_BITS = $clog2(LINE_BITS / 8);
   localparam logic [3:0] CNT_LOAD    = 4'(LATENCY - 1);

   pmem_state_t           state;
   logic [3:0]            cnt;
   logic                  op_write;
   logic [INDEX_BITS-1:0] index_reg;
   logic [LINE_BITS-1:0]  wdata_reg;
   logic [LINE_BITS-1:0]  rdata_hold;
   logic [LINE_BITS-1:0]  sram_rd;
   logic [INDEX_BITS-1:0] addr_index;
   logic [INDEX_BITS-1:0] rd_addr;
   logic                  wr_en;
   logic                  req;
   logic                  unused_addr_bits;

   assign req        = pmem_read | pmem_write;
   assign addr_index = pmem_address[OFFSET_BITS +: INDEX_BITS];
   assign unused_addr_bits = ^{pmem_address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS],
                               pmem_address[OFFSET_BITS-1:0]};

   // Read the incoming index while idle so a LATENCY==1 read has its line by the RESP cycle.
   assign rd_addr = (state == PM_IDLE) ? addr_index : index_reg;
   assign wr_en   = (state == PM_RESP) && op_write;

   line_sram #(
      .INDEX_BITS (INDEX_BITS),
      .LINE_BITS  (LINE_BITS)
   ) u_sram (
      .clk     (clk),
      .rd_addr (rd_addr),
      .rd_data (sram_rd),
      .wr_en   (wr_en),
      .wr_addr (index_reg),
      .wr_data (wdata_reg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= PM_IDLE;
         cnt        <= 4'd0;
         op_write   <= 1'b0;
         index_reg  <= '0;
         wdata_reg  <= '0;
         rdata_hold <= '0;
         pmem_resp  <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         pmem_resp <= 1'b0;
         case (state)
            PM_IDLE: begin
               if (req) begin
                  op_write  <= pmem_write;
                  index_reg <= addr_index;
                  wdata_reg <= pmem_wdata;
                  cnt       <= CNT_LOAD;
                  if (pmem_read && pmem_write) begin
                     proto_err <= 1'b1;
                  end
                  if (LATENCY == 1) begin
                     state     <= PM_RESP;
                     pmem_resp <= 1'b1;
                  end else begin
                     state <= PM_BUSY;
                  end
               end
            end
            PM_BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state     <= PM_RESP;
                  pmem_resp <= 1'b1;
               end
            end
            PM_RESP: begin
               state <= PM_IDLE;
               if (!op_write) begin
                  rdata_hold <= sram_rd;
               end
            end
            default: state <= PM_IDLE;
         endcase
      end
   end

   // The fresh SRAM line is shown during the RESP cycle of a read, then held.
   assign pmem_rdata = (state == PM_RESP && !op_write) ? sram_rd : rdata_hold;
endmodule
